// File: rtl/seq_checker.sv
// Sequence checker: locks onto the cyclic sequence 2,9,4,1,6,3,8 from an upstream
// counter, flags out-of-order samples while locked and keeps error and cycle statistics.
module seq_checker #(
    parameter int LOCK_N   = 2,
    parameter int UNLOCK_N = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] din,
    input  logic       din_valid,
    output logic       locked,
    output logic       err,
    output logic [7:0] err_count,
    output logic [7:0] cycle_count,
    output logic [3:0] expected
);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        CONFIRM = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam logic [2:0] LOCK_C   = 3'(LOCK_N);
    localparam logic [2:0] UNLOCK_C = 3'(UNLOCK_N);
    localparam logic [2:0] LAST_IDX = 3'd6;

    function automatic logic [3:0] seq_val(input logic [2:0] idx);
        case (idx)
            3'd0:    seq_val = 4'd2;
            3'd1:    seq_val = 4'd9;
            3'd2:    seq_val = 4'd4;
            3'd3:    seq_val = 4'd1;
            3'd4:    seq_val = 4'd6;
            3'd5:    seq_val = 4'd3;
            3'd6:    seq_val = 4'd8;
            default: seq_val = 4'd0;
        endcase
    endfunction

    function automatic logic [2:0] next_idx(input logic [2:0] idx);
        next_idx = (idx == LAST_IDX) ? 3'd0 : idx + 3'd1;
    endfunction

    state_t     state, state_n;
    logic [2:0] exp_idx, idx_n;
    logic [2:0] match_cnt, match_n;
    logic [2:0] miss_cnt, miss_n;
    logic       err_n;
    logic [7:0] err_count_n, cycle_count_n;
    logic [3:0] expected_n;
    logic       hit;
    logic [2:0] hit_idx;
    logic       match;

    // NOTE: every variable gets a default before any branch so no latch is inferred.
    always_comb begin
        hit     = 1'b0;
        hit_idx = 3'd0;
        for (int k = 0; k < 7; k++) begin
            if (din == seq_val(3'(k))) begin
                hit     = 1'b1;
                hit_idx = 3'(k);
            end
        end
    end

    assign match = (din == seq_val(exp_idx));

    always_comb begin
        state_n       = state;
        idx_n         = exp_idx;
        match_n       = match_cnt;
        miss_n        = miss_cnt;
        err_n         = 1'b0;
        err_count_n   = err_count;
        cycle_count_n = cycle_count;

        if (din_valid) begin
            case (state)
                HUNT: begin
                    // Values outside the table (including the upstream reset word 0) are ignored.
                    if (hit) begin
                        idx_n   = next_idx(hit_idx);
                        match_n = 3'd1;
                        miss_n  = 3'd0;
                        state_n = (LOCK_C == 3'd1) ? LOCKED : CONFIRM;
                    end
                end
                CONFIRM: begin
                    if (match) begin
                        idx_n   = next_idx(exp_idx);
                        match_n = match_cnt + 3'd1;
                        if (match_cnt + 3'd1 == LOCK_C) begin
                            state_n = LOCKED;
                            miss_n  = 3'd0;
                        end
                    end else begin
                        state_n = HUNT;
                        match_n = 3'd0;
                        idx_n   = 3'd0;
                    end
                end
                LOCKED: begin
                    idx_n = next_idx(exp_idx);
                    if (match) begin
                        miss_n = 3'd0;
                        if (exp_idx == LAST_IDX)
                            cycle_count_n = cycle_count + 8'd1;
                    end else begin
                        err_n  = 1'b1;
                        miss_n = miss_cnt + 3'd1;
                        if (err_count != 8'hFF)
                            err_count_n = err_count + 8'd1;
                        // Freewheel through isolated glitches; give up after UNLOCK_N in a row.
                        if (miss_cnt + 3'd1 == UNLOCK_C) begin
                            state_n = HUNT;
                            idx_n   = 3'd0;
                            miss_n  = 3'd0;
                            match_n = 3'd0;
                        end
                    end
                end
                default: begin
                    state_n = HUNT;
                    idx_n   = 3'd0;
                    match_n = 3'd0;
                    miss_n  = 3'd0;
                end
            endcase
        end

        expected_n = (state_n == HUNT) ? 4'h0 : seq_val(idx_n);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= HUNT;
            exp_idx     <= 3'd0;
            match_cnt   <= 3'd0;
            miss_cnt    <= 3'd0;
            locked      <= 1'b0;
            err         <= 1'b0;
            err_count   <= 8'd0;
            cycle_count <= 8'd0;
            expected    <= 4'h0;
        end else begin
            state       <= state_n;
            exp_idx     <= idx_n;
            match_cnt   <= match_n;
            miss_cnt    <= miss_n;
            locked      <= (state_n == LOCKED);
            err         <= err_n;
            err_count   <= err_count_n;
            cycle_count <= cycle_count_n;
            expected    <= expected_n;
        end
    end

endmodule

// File: tb/tb_seq_checker.sv
// Directed self-checking bench for seq_checker with default LOCK_N=2, UNLOCK_N=3.
module tb_seq_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] din;
    logic       din_valid;
    logic       locked;
    logic       err;
    logic [7:0] err_count;
    logic [7:0] cycle_count;
    logic [3:0] expected;

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] seq_tab [7] = '{4'd2, 4'd9, 4'd4, 4'd1, 4'd6, 4'd3, 4'd8};

    seq_checker dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .locked      (locked),
        .err         (err),
        .err_count   (err_count),
        .cycle_count (cycle_count),
        .expected    (expected)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply one sample, then sample outputs 1 ns after the capturing edge.
    task automatic step(input logic v, input logic [3:0] d);
        din_valid = v;
        din       = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".locked"}, 32'(locked), 0);
        check({tag, ".err"}, 32'(err), 0);
        check({tag, ".err_count"}, 32'(err_count), 0);
        check({tag, ".cycle_count"}, 32'(cycle_count), 0);
        check({tag, ".expected"}, 32'(expected), 0);
    endtask

    initial begin
        rst = 1'b1; din = 4'd0; din_valid = 1'b0;
        #1;
        check_all_zero("reset");
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Clean lock from the upstream reset word.
        step(1, 4'd0);  check("lock.0.locked", 32'(locked), 0);
        step(1, 4'd2);  check("lock.2.locked", 32'(locked), 0);
                        check("lock.2.expected", 32'(expected), 9);
        step(1, 4'd9);  check("lock.9.locked", 32'(locked), 1);
                        check("lock.9.expected", 32'(expected), 4);
        step(1, 4'd4);  check("lock.4.err", 32'(err), 0);
        step(1, 4'd1);  check("lock.1.err", 32'(err), 0);
        step(1, 4'd6);  check("lock.6.err", 32'(err), 0);
        step(1, 4'd3);  check("lock.3.cycle", 32'(cycle_count), 0);
        step(1, 4'd8);  check("lock.8.cycle", 32'(cycle_count), 1);
                        check("lock.8.err", 32'(err), 0);
        step(1, 4'd2);  check("lock.2b.expected", 32'(expected), 9);
                        check("lock.2b.err_count", 32'(err_count), 0);

        // Single glitch while locked.
        step(1, 4'd9);  check("glitch.pre.expected", 32'(expected), 4);
        step(1, 4'd5);  check("glitch.err", 32'(err), 1);
                        check("glitch.err_count", 32'(err_count), 1);
                        check("glitch.locked", 32'(locked), 1);
                        check("glitch.freewheel", 32'(expected), 1);
        step(1, 4'd1);  check("glitch.resume1.err", 32'(err), 0);
        step(1, 4'd6);  check("glitch.resume6.err", 32'(err), 0);
                        check("glitch.resume6.count", 32'(err_count), 1);
                        check("glitch.resume6.expected", 32'(expected), 3);

        // Invalid cycles change nothing even with an out-of-table din.
        for (int i = 0; i < 5; i++) begin
            step(0, 4'd15);
            check("gate.err", 32'(err), 0);
            check("gate.expected", 32'(expected), 3);
        end
        step(1, 4'd3);  check("gate.resume3.err", 32'(err), 0);
        step(1, 4'd8);  check("gate.resume8.cycle", 32'(cycle_count), 2);
                        check("gate.resume8.expected", 32'(expected), 2);

        // Loss of lock after three consecutive mismatches.
        step(1, 4'd15); check("loss1.err", 32'(err), 1);
                        check("loss1.count", 32'(err_count), 2);
                        check("loss1.locked", 32'(locked), 1);
        step(1, 4'd15); check("loss2.count", 32'(err_count), 3);
                        check("loss2.locked", 32'(locked), 1);
        step(1, 4'd15); check("loss3.err", 32'(err), 1);
                        check("loss3.count", 32'(err_count), 4);
                        check("loss3.locked", 32'(locked), 0);
                        check("loss3.expected", 32'(expected), 0);
        step(0, 4'd0);  check("loss.after.err", 32'(err), 0);

        // Out-of-table in HUNT, then a mismatch in CONFIRM: no err either way.
        step(1, 4'd7);  check("hunt7.err", 32'(err), 0);
                        check("hunt7.expected", 32'(expected), 0);
        step(1, 4'd2);  check("confirm.expected", 32'(expected), 9);
                        check("confirm.locked", 32'(locked), 0);
        step(1, 4'd4);  check("confirm.miss.err", 32'(err), 0);
                        check("confirm.miss.expected", 32'(expected), 0);
                        check("confirm.miss.count", 32'(err_count), 4);
                        check("persist.cycle", 32'(cycle_count), 2);

        // Asynchronous reset mid-lock, then re-lock.
        step(1, 4'd2);
        step(1, 4'd9);  check("relock.locked", 32'(locked), 1);
        #2 rst = 1'b1;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        step(1, 4'd2);
        step(1, 4'd9);  check("postrst.locked", 32'(locked), 1);
                        check("postrst.expected", 32'(expected), 4);

        // err_count saturation: 100 rounds of relock plus three mismatches.
        step(1, 4'd15); step(1, 4'd15); step(1, 4'd15);
        check("sat.pre.count", 32'(err_count), 3);
        for (int r = 0; r < 99; r++) begin
            step(1, 4'd2); step(1, 4'd9);
            step(1, 4'd15); step(1, 4'd15); step(1, 4'd15);
        end
        check("sat.count", 32'(err_count), 255);
        check("sat.locked", 32'(locked), 0);

        // cycle_count wrap: 257 completed cycles while locked.
        rst = 1'b1;
        #1;
        check_all_zero("wraprst");
        @(negedge clk);
        rst = 1'b0;
        step(1, 4'd2); step(1, 4'd9);
        for (int i = 2; i < 7; i++) step(1, seq_tab[i]);
        check("wrap.first", 32'(cycle_count), 1);
        for (int c = 0; c < 256; c++)
            for (int i = 0; i < 7; i++) step(1, seq_tab[i]);
        check("wrap.count", 32'(cycle_count), 1);
        check("wrap.errs", 32'(err_count), 0);
        check("wrap.locked", 32'(locked), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_checker.md
SEQ_CHECKER -- requirements
Module: seq_checker

Interface
REQ-001 Parameter LOCK_N, default 2, SHALL set the number of consecutive in-order matches needed to lock (legal 1..7).
REQ-002 Parameter UNLOCK_N, default 3, SHALL set the number of consecutive mismatches while locked that cause loss of lock (legal 1..7).
REQ-003 clk  input  1  SHALL be the clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 din  input  4  SHALL carry the sample word from the upstream arbitrary-sequence counter.
REQ-006 din_valid  input  1  SHALL qualify din; din SHALL be ignored when low.
REQ-007 locked  output  1  SHALL be high while the FSM is in LOCKED.
REQ-008 err  output  1  SHALL be a one-cycle pulse flagging an out-of-sequence sample while locked.
REQ-009 err_count  output  8  SHALL be the saturating count of err pulses.
REQ-010 cycle_count  output  8  SHALL be the wrapping count of completed sequence cycles while locked.
REQ-011 expected  output  4  SHALL show the next expected value: table[exp_idx] in CONFIRM/LOCKED, 4'h0 in HUNT.

Function
REQ-012 The sequence table SHALL be idx 0..6 = 2, 9, 4, 1, 6, 3, 8, cyclic; exp_idx SHALL increment mod 7 (6 -> 0).
REQ-013 The FSM SHALL have exactly three states: HUNT, CONFIRM, LOCKED; all outputs SHALL be registered.
REQ-014 A cycle with din_valid=0 SHALL change no state, index or counter, and err SHALL be 0.
REQ-015 In HUNT, a valid din equal to table[k] SHALL set exp_idx=(k+1) mod 7 and match_cnt=1, then go to CONFIRM (directly to LOCKED if LOCK_N=1).
REQ-016 In HUNT, a valid din not in the table (0, 5, 7, 10..15) SHALL leave the FSM in HUNT with no err; 0 is the upstream reset word and SHALL be tolerated.
REQ-017 In CONFIRM, valid din==table[exp_idx] SHALL advance exp_idx and increment match_cnt; reaching LOCK_N SHALL move the FSM to LOCKED with miss_cnt=0.
REQ-018 In CONFIRM, a valid mismatch SHALL return the FSM to HUNT, clear match_cnt, discard the sample and raise no err.
REQ-019 In LOCKED, a valid match SHALL advance exp_idx and clear miss_cnt; if the matched value is 8 (idx 6), cycle_count SHALL increment, wrapping 255 -> 0.
REQ-020 In LOCKED, a valid mismatch SHALL pulse err for exactly one cycle, increment err_count (saturating at 255), still advance exp_idx (freewheel), and increment miss_cnt.
REQ-021 When miss_cnt reaches UNLOCK_N, the FSM SHALL enter HUNT on that same edge; err SHALL still pulse for that sample, and exp_idx and miss_cnt SHALL clear.
REQ-022 Latency: locked, err, expected and the counters SHALL reflect a sample on the clock edge that samples it, and SHALL be visible in the following cycle.
REQ-023 err_count and cycle_count SHALL persist across HUNT/CONFIRM/LOCKED transitions; only rst SHALL clear them.

Reset
REQ-024 On rst high, the block SHALL immediately enter HUNT with: locked=0, err=0, err_count=0, cycle_count=0, expected=0, exp_idx=0, match_cnt=0, miss_cnt=0.
REQ-025 An rst asserted mid-operation (any state) SHALL abort at once to the REQ-024 values; the first valid sample after release SHALL be treated as in HUNT.

Verification
REQ-026 Clean lock: rst, then valid din 0,2,9,4,1,6,3,8,2 -> locked=1 after the 9 is sampled, err never 1, cycle_count=1 after the 8, expected=9 after the final 2.
REQ-027 Single glitch: locked, expected=4, inject din=5 then resume 1,6 -> one err pulse, err_count=1, locked stays 1, no further errors.
REQ-028 Loss of lock: locked, inject 3 consecutive invalid-order values (15,15,15) -> three err pulses, err_count=3, locked=0 after the third, expected=0.
REQ-029 Valid gating: locked stream with din_valid=0 for 5 cycles while din=15 -> no err, exp_idx unchanged, stream resumes with no error.
REQ-030 Saturation/wrap: force 300 mismatches (re-lock as needed) -> err_count holds 255; run 257 full cycles locked -> cycle_count=1.
REQ-031 Reset mid-lock: assert rst while locked with err_count=2 -> all outputs 0 immediately, HUNT; a 2,9 stream re-locks.
